fft_peak_detect: RTL and testbench



---
 rtl/fft_pkg.sv | 24 ++
 rtl/fft_mag_sq.sv | 96 +++++++++
 rtl/fft_peak_detect.sv | 224 ++++++++++++++++++++++
 tb/tb_fft_peak_detect.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared constants and types for the FFT peak detector.
//   DATA_W  : width of the signed real/imag samples from the FFT core
//   N_POINT : FFT frame length in beats
//   BIN_W   : bin index width, log2(N_POINT)
//   MAG_W   : width of the unsigned power value re^2 + im^2
//   state_e : frame-tracking FSM states
// ---------------------------------------------------------------------------
package fft_pkg;

   localparam int unsigned DATA_W  = 16;
   localparam int unsigned N_POINT = 512;
   localparam int unsigned BIN_W   = 9;
   localparam int unsigned MAG_W   = 2 * DATA_W;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StFlush,
      StReport
   } state_e;

endpackage

// File: rtl/fft_mag_sq.sv
// ---------------------------------------------------------------------------
// fft_mag_sq
// Pipeline that computes the power of one complex FFT beat.
//   S1 registers the sample and its sideband (first-of-frame, bin, in_range).
//   S2 registers the signed squares re*re and im*im.
//   The S2 outputs drive a combinational sum; the consumer registers its
//   result on the same edge, which forms the third stage.
// Ports:
//   i_clk, i_rst_n             : clock, synchronous active-low reset
//   i_valid                    : beat enters the pipeline
//   i_first, i_bin, i_in_range : sideband carried with the beat
//   i_re, i_im                 : signed sample
//   o_valid, o_first, o_bin, o_in_range : sideband aligned with o_sum
//   o_sum                      : re^2 + im^2, unsigned, 2*DATA_W bits
// ---------------------------------------------------------------------------
module fft_mag_sq #(
   parameter int unsigned DATA_W = fft_pkg::DATA_W,
   parameter int unsigned BIN_W  = fft_pkg::BIN_W
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_valid,
   input  logic                       i_first,
   input  logic                       i_in_range,
   input  logic [BIN_W-1:0]           i_bin,
   input  logic signed [DATA_W-1:0]   i_re,
   input  logic signed [DATA_W-1:0]   i_im,
   output logic                       o_valid,
   output logic                       o_first,
   output logic                       o_in_range,
   output logic [BIN_W-1:0]           o_bin,
   output logic [2*DATA_W-1:0]        o_sum
);

   // Stage 1 registers
   logic                       r_s1_valid;
   logic                       r_s1_first;
   logic                       r_s1_in_range;
   logic [BIN_W-1:0]           r_s1_bin;
   logic signed [DATA_W-1:0]   r_s1_re;
   logic signed [DATA_W-1:0]   r_s1_im;

   // Stage 2 registers
   logic                       r_s2_valid;
   logic                       r_s2_first;
   logic                       r_s2_in_range;
   logic [BIN_W-1:0]           r_s2_bin;
   logic signed [2*DATA_W-1:0] r_s2_sq_re;
   logic signed [2*DATA_W-1:0] r_s2_sq_im;

   logic signed [2*DATA_W-1:0] w_sq_re;
   logic signed [2*DATA_W-1:0] w_sq_im;

   // Operands are sign-extended to the full product width before multiplying.
   assign w_sq_re = r_s1_re * r_s1_re;
   assign w_sq_im = r_s1_im * r_s1_im;

   // Valid flags are the only state that reset must clear.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_s1_valid <= 1'b0;
         r_s2_valid <= 1'b0;
      end else begin
         r_s1_valid <= i_valid;
         r_s2_valid <= r_s1_valid;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_valid) begin
         r_s1_first    <= i_first;
         r_s1_in_range <= i_in_range;
         r_s1_bin      <= i_bin;
         r_s1_re       <= i_re;
         r_s1_im       <= i_im;
      end
   end

   always_ff @(posedge i_clk) begin
      if (r_s1_valid) begin
         r_s2_first    <= r_s1_first;
         r_s2_in_range <= r_s1_in_range;
         r_s2_bin      <= r_s1_bin;
         r_s2_sq_re    <= w_sq_re;
         r_s2_sq_im    <= w_sq_im;
      end
   end

   // Each square is at most 2^(2*DATA_W-2), so the sum fits without overflow.
   assign o_sum      = $unsigned(r_s2_sq_re) + $unsigned(r_s2_sq_im);
   assign o_valid    = r_s2_valid;
   assign o_first    = r_s2_first;
   assign o_in_range = r_s2_in_range;
   assign o_bin      = r_s2_bin;

endmodule

// File: rtl/fft_peak_detect.sv
// ---------------------------------------------------------------------------
// fft_peak_detect
// Sink for the FFT core output stream. Tags each accepted beat with its bin,
// computes its power, tracks the strongest in-range bin and reports it once
// per well-formed frame. Malformed frames raise a one-cycle frame_err pulse.
// Ports:
//   i_clk, i_rst_n                  : clock, synchronous active-low reset
//   i_fft_out_valid/sop/eop         : stream control from the FFT core
//   i_fft_out_real, i_fft_out_imag  : signed sample
//   o_fft_out_ready                 : sink ready to the FFT core
//   o_peak_bin, o_peak_mag          : last reported peak, held
//   o_peak_valid                    : one-cycle pulse when the peak updates
//   o_frame_err                     : one-cycle pulse on a malformed frame
// ---------------------------------------------------------------------------
module fft_peak_detect
   import fft_pkg::*;
#(
   parameter int unsigned DATA_W      = fft_pkg::DATA_W,
   parameter int unsigned N_POINT     = fft_pkg::N_POINT,
   parameter int unsigned BIN_W       = fft_pkg::BIN_W,
   parameter int unsigned SEARCH_HALF = 1,
   parameter int unsigned SKIP_DC     = 1
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_fft_out_valid,
   input  logic                       i_fft_out_sop,
   input  logic                       i_fft_out_eop,
   input  logic signed [DATA_W-1:0]   i_fft_out_real,
   input  logic signed [DATA_W-1:0]   i_fft_out_imag,
   output logic                       o_fft_out_ready,
   output logic [BIN_W-1:0]           o_peak_bin,
   output logic [2*DATA_W-1:0]        o_peak_mag,
   output logic                       o_peak_valid,
   output logic                       o_frame_err
);

   localparam int unsigned      MagW       = 2 * DATA_W;
   localparam logic [BIN_W-1:0] LastBin    = BIN_W'(N_POINT - 1);
   localparam logic [BIN_W-1:0] HalfBin    = BIN_W'(N_POINT / 2);
   localparam bit               SearchHalf = (SEARCH_HALF != 0);
   localparam bit               SkipDc     = (SKIP_DC != 0);
   // Edges spent in FLUSH: the last beat clears the pipeline two edges after
   // acceptance; the extra edges align the report five edges after eop.
   localparam logic [1:0]       FlushLast  = 2'd3;

   state_e           r_state;
   state_e           w_state_d;
   logic [BIN_W-1:0] r_bin_cnt;
   logic [BIN_W-1:0] w_bin_cnt_d;
   logic [1:0]       r_flush_cnt;
   logic [1:0]       w_flush_cnt_d;
   logic             r_ready;
   logic             r_peak_valid;
   logic             r_frame_err;
   logic [BIN_W-1:0] r_peak_bin;
   logic [MagW-1:0]  r_peak_mag;
   logic [BIN_W-1:0] r_best_bin;
   logic [MagW-1:0]  r_best_mag;

   logic             w_accept;
   logic             w_frame_err_d;
   logic             w_report;
   logic             w_pipe_valid;
   logic             w_pipe_first;
   logic [BIN_W-1:0] w_pipe_bin;
   logic             w_pipe_in_range;

   logic             w_sq_valid;
   logic             w_sq_first;
   logic             w_sq_in_range;
   logic [BIN_W-1:0] w_sq_bin;
   logic [MagW-1:0]  w_sq_sum;
   logic [BIN_W-1:0] w_base_bin;
   logic [MagW-1:0]  w_base_mag;
   logic             w_take;

   assign w_accept = i_fft_out_valid && r_ready;

   // ------------------------------------------------------------------------
   // Frame FSM: next state, beat tagging and error detection
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_d     = r_state;
      w_bin_cnt_d   = r_bin_cnt;
      w_flush_cnt_d = r_flush_cnt;
      w_frame_err_d = 1'b0;
      w_report      = 1'b0;
      w_pipe_valid  = 1'b0;
      w_pipe_first  = 1'b0;
      w_pipe_bin    = r_bin_cnt;

      unique case (r_state)
         StIdle: begin
            // Beats outside a frame are dropped until a sop arrives.
            if (w_accept && i_fft_out_sop) begin
               w_pipe_valid = 1'b1;
               w_pipe_first = 1'b1;
               w_pipe_bin   = '0;
               w_bin_cnt_d  = BIN_W'(1);
               w_state_d    = StRun;
            end
         end
         StRun: begin
            if (w_accept) begin
               w_pipe_valid = 1'b1;
               if (i_fft_out_sop) begin
                  // Unexpected sop: flag it and restart the frame on this beat.
                  w_frame_err_d = 1'b1;
                  w_pipe_first  = 1'b1;
                  w_pipe_bin    = '0;
                  w_bin_cnt_d   = BIN_W'(1);
               end else begin
                  w_pipe_bin  = r_bin_cnt;
                  w_bin_cnt_d = r_bin_cnt + 1'b1;
                  if (i_fft_out_eop) begin
                     if (r_bin_cnt == LastBin) begin
                        w_flush_cnt_d = '0;
                        w_state_d     = StFlush;
                     end else begin
                        w_frame_err_d = 1'b1;
                        w_state_d     = StIdle;
                     end
                  end else if (r_bin_cnt == LastBin) begin
                     w_frame_err_d = 1'b1;
                     w_state_d     = StIdle;
                  end
               end
            end
         end
         StFlush: begin
            if (r_flush_cnt == FlushLast) begin
               w_state_d = StReport;
            end else begin
               w_flush_cnt_d = r_flush_cnt + 1'b1;
            end
         end
         StReport: begin
            w_report  = 1'b1;
            w_state_d = StIdle;
         end
         default: begin
            w_state_d = StIdle;
         end
      endcase
   end

   assign w_pipe_in_range = (!SearchHalf || (w_pipe_bin < HalfBin)) &&
                            (!SkipDc || (w_pipe_bin != '0));

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state      <= StIdle;
         r_bin_cnt    <= '0;
         r_flush_cnt  <= '0;
         r_ready      <= 1'b0;
         r_peak_valid <= 1'b0;
         r_frame_err  <= 1'b0;
         r_peak_bin   <= '0;
         r_peak_mag   <= '0;
      end else begin
         r_state      <= w_state_d;
         r_bin_cnt    <= w_bin_cnt_d;
         r_flush_cnt  <= w_flush_cnt_d;
         // Ready is registered from the next state so it is glitch-free.
         r_ready      <= (w_state_d == StIdle) || (w_state_d == StRun);
         r_peak_valid <= w_report;
         r_frame_err  <= w_frame_err_d;
         if (w_report) begin
            r_peak_bin <= r_best_bin;
            r_peak_mag <= r_best_mag;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Power pipeline
   // ------------------------------------------------------------------------
   fft_mag_sq #(
      .DATA_W (DATA_W),
      .BIN_W  (BIN_W)
   ) u_mag_sq (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_valid    (w_pipe_valid),
      .i_first    (w_pipe_first),
      .i_in_range (w_pipe_in_range),
      .i_bin      (w_pipe_bin),
      .i_re       (i_fft_out_real),
      .i_im       (i_fft_out_imag),
      .o_valid    (w_sq_valid),
      .o_first    (w_sq_first),
      .o_in_range (w_sq_in_range),
      .o_bin      (w_sq_bin),
      .o_sum      (w_sq_sum)
   );

   // ------------------------------------------------------------------------
   // Running maximum. The max is cleared when the frame's first beat reaches
   // this stage rather than when it is accepted, so beats of an aborted frame
   // still in flight cannot leak into the new frame.
   // ------------------------------------------------------------------------
   assign w_base_mag = w_sq_first ? '0 : r_best_mag;
   assign w_base_bin = w_sq_first ? '0 : r_best_bin;
   // Strict compare keeps the lowest bin on ties.
   assign w_take     = w_sq_in_range && (w_sq_sum > w_base_mag);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_best_mag <= '0;
         r_best_bin <= '0;
      end else if (w_sq_valid) begin
         r_best_mag <= w_take ? w_sq_sum : w_base_mag;
         r_best_bin <= w_take ? w_sq_bin : w_base_bin;
      end
   end

   assign o_fft_out_ready = r_ready;
   assign o_peak_bin      = r_peak_bin;
   assign o_peak_mag      = r_peak_mag;
   assign o_peak_valid    = r_peak_valid;
   assign o_frame_err     = r_frame_err;

endmodule

// File: tb/tb_fft_peak_detect.sv
// ---------------------------------------------------------------------------
// tb_fft_peak_detect
// Self-checking bench for fft_peak_detect with default parameters
// (SEARCH_HALF=1, SKIP_DC=1). Expected reports come from a reference scan of
// the frame contents and are queued when a frame is driven; the monitor
// queues observed reports, which each test pops and compares.
// ---------------------------------------------------------------------------
module tb_fft_peak_detect;

   localparam int DW = 16;
   localparam int NP = 512;
   localparam int BW = 9;
   localparam int MW = 32;

   typedef struct packed {
      logic [BW-1:0] bin;
      logic [MW-1:0] mag;
      int            cyc;
   } rpt_t;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 valid;
   logic                 sop;
   logic                 eop;
   logic signed [DW-1:0] re;
   logic signed [DW-1:0] im;
   logic                 ready;
   logic [BW-1:0]        pbin;
   logic [MW-1:0]        pmag;
   logic                 pvalid;
   logic                 ferr;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   err_cnt  = 0;
   int   cyc      = 0;
   int   t_eop    = 0;
   rpt_t exp_q[$];
   rpt_t obs_q[$];
   rpt_t mon_r;
   logic signed [DW-1:0] fre[NP];
   logic signed [DW-1:0] fim[NP];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fft_peak_detect dut (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .i_fft_out_valid (valid),
      .i_fft_out_sop   (sop),
      .i_fft_out_eop   (eop),
      .i_fft_out_real  (re),
      .i_fft_out_imag  (im),
      .o_fft_out_ready (ready),
      .o_peak_bin      (pbin),
      .o_peak_mag      (pmag),
      .o_peak_valid    (pvalid),
      .o_frame_err     (ferr)
   );

   // Monitor: collect reports, count error pulses, check exclusivity.
   always @(negedge clk) begin
      if (pvalid) begin
         mon_r.bin = pbin;
         mon_r.mag = pmag;
         mon_r.cyc = cyc;
         obs_q.push_back(mon_r);
      end
      if (ferr) err_cnt++;
      if (pvalid || ferr) begin
         n_checks++;
         if (pvalid && ferr) begin
            n_fail++;
            $display("FAIL err_vs_report: peak_valid=%b frame_err=%b, want not both", pvalid, ferr);
         end
      end
   end

   task automatic clear_frame();
      for (int i = 0; i < NP; i++) begin
         fre[i] = '0;
         fim[i] = '0;
      end
   endtask

   // Reference: strongest bin in 1..NP/2-1, strict compare, zero if none.
   task automatic push_expected();
      longint best = 0;
      int     bbin = 0;
      rpt_t   e;
      for (int i = 1; i < NP / 2; i++) begin
         longint a = fre[i];
         longint b = fim[i];
         longint m = a * a + b * b;
         if (m > best) begin
            best = m;
            bbin = i;
         end
      end
      e.bin = bbin[BW-1:0];
      e.mag = best[MW-1:0];
      e.cyc = 0;
      exp_q.push_back(e);
   endtask

   task automatic drive_beat(input logic signed [DW-1:0] r, input logic signed [DW-1:0] q,
                             input bit s, input bit e, output bit ok);
      int guard = 0;
      @(negedge clk);
      valid = 1'b1;
      sop   = s;
      eop   = e;
      re    = r;
      im    = q;
      while (!ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      ok = ready;
      if (ok) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive_frame(input int nbeats, input int eop_at, input bit gaps);
      bit ok = 1'b1;
      for (int i = 0; i < nbeats && ok; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            @(negedge clk);
            valid = 1'b0;
            @(posedge clk);
         end
         drive_beat(fre[i], fim[i], i == 0, i == eop_at, ok);
         if (ok && i == eop_at) t_eop = cyc;
      end
      @(negedge clk);
      valid = 1'b0;
      sop   = 1'b0;
      eop   = 1'b0;
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL beat_accept: ready stayed %b for 100 cycles, want 1", ready);
      end
   endtask

   task automatic wait_report(output bit got);
      int g = 0;
      while (obs_q.size() == 0 && g < 40) begin
         @(posedge clk);
         g++;
      end
      got = (obs_q.size() != 0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      valid = 1'b0;
      sop   = 1'b0;
      eop   = 1'b0;
      re    = '0;
      im    = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks += 5;
      if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready); end
      if (pvalid !== 1'b0) begin n_fail++; $display("FAIL reset_pvalid: got %b want 0", pvalid); end
      if (ferr !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b want 0", ferr); end
      if (pbin !== '0) begin n_fail++; $display("FAIL reset_bin: got %0d want 0", pbin); end
      if (pmag !== '0) begin n_fail++; $display("FAIL reset_mag: got %0d want 0", pmag); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got %b want 1", ready); end
   endtask

   task automatic test_single_tone();
      bit   got;
      rpt_t e;
      rpt_t o;
      int   e0 = err_cnt;
      clear_frame();
      fre[37] = 16'sd1000;
      push_expected();
      drive_frame(NP, NP - 1, 1'b0);
      wait_report(got);
      n_checks++;
      if (!got) begin
         n_fail++;
         $display("FAIL tone_report: got no peak_valid want one");
      end else begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_checks += 3;
         if (o.bin !== e.bin) begin n_fail++; $display("FAIL tone_bin: got %0d want %0d", o.bin, e.bin); end
         if (o.mag !== e.mag) begin n_fail++; $display("FAIL tone_mag: got %0d want %0d", o.mag, e.mag); end
         if (o.cyc - t_eop !== 5) begin n_fail++; $display("FAIL tone_latency: got %0d want 5", o.cyc - t_eop); end
      end
      n_checks++;
      if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL tone_err: got %0d want 0", err_cnt - e0); end
   endtask

   task automatic test_mirror_bin();
      bit   got;
      rpt_t e;
      rpt_t o;
      clear_frame();
      fre[475] = 16'sd5000;
      fre[37]  = 16'sd100;
      push_expected();
      drive_frame(NP, NP - 1, 1'b1);
      wait_report(got);
      n_checks++;
      if (!got) begin
         n_fail++;
         $display("FAIL mirror_report: got no peak_valid want one");
      end else begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_checks += 3;
         if (o.bin !== e.bin) begin n_fail++; $display("FAIL mirror_bin: got %0d want %0d", o.bin, e.bin); end
         if (o.mag !== e.mag) begin n_fail++; $display("FAIL mirror_mag: got %0d want %0d", o.mag, e.mag); end
         if (o.cyc - t_eop !== 5) begin n_fail++; $display("FAIL mirror_latency: got %0d want 5", o.cyc - t_eop); end
      end
   endtask

   task automatic test_tie_negative();
      bit   got;
      rpt_t e;
      rpt_t o;
      clear_frame();
      fre[10] = -16'sd300;
      fim[10] = 16'sd400;
      fre[20] = 16'sd500;
      push_expected();
      drive_frame(NP, NP - 1, 1'b1);
      wait_report(got);
      n_checks++;
      if (!got) begin
         n_fail++;
         $display("FAIL tie_report: got no peak_valid want one");
      end else begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_checks += 2;
         if (o.bin !== e.bin) begin n_fail++; $display("FAIL tie_bin: got %0d want %0d", o.bin, e.bin); end
         if (o.mag !== e.mag) begin n_fail++; $display("FAIL tie_mag: got %0d want %0d", o.mag, e.mag); end
      end
   endtask

   task automatic test_early_eop();
      bit   got;
      rpt_t e;
      rpt_t o;
      int   e0 = err_cnt;
      clear_frame();
      fre[10] = 16'sd999;
      drive_frame(301, 300, 1'b0);
      repeat (20) @(posedge clk);
      n_checks += 2;
      if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL early_eop_err: got %0d pulses want 1", err_cnt - e0); end
      if (obs_q.size() !== 0) begin n_fail++; $display("FAIL early_eop_report: got %0d reports want 0", obs_q.size()); end
      // Largest possible power: both parts at the most negative value.
      clear_frame();
      fre[200] = -16'sd32768;
      fim[200] = -16'sd32768;
      fre[100] = 16'sd32767;
      fim[100] = 16'sd32767;
      push_expected();
      drive_frame(NP, NP - 1, 1'b1);
      wait_report(got);
      n_checks++;
      if (!got) begin
         n_fail++;
         $display("FAIL recover_report: got no peak_valid want one");
      end else begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_checks += 3;
         if (o.bin !== e.bin) begin n_fail++; $display("FAIL recover_bin: got %0d want %0d", o.bin, e.bin); end
         if (o.mag !== e.mag) begin n_fail++; $display("FAIL recover_mag: got %0d want %0d", o.mag, e.mag); end
         if (o.cyc - t_eop !== 5) begin n_fail++; $display("FAIL recover_latency: got %0d want 5", o.cyc - t_eop); end
      end
   endtask

   task automatic test_sop_restart();
      bit   got;
      rpt_t e;
      rpt_t o;
      int   e0 = err_cnt;
      // Aborted frame: its strong bin must not survive the restart.
      clear_frame();
      fre[50] = 16'sd20000;
      drive_frame(100, -1, 1'b0);
      clear_frame();
      fre[0]   = 16'sd32767;
      fre[256] = -16'sd30000;
      fre[300] = 16'sd30000;
      fre[7]   = 16'sd2;
      fre[255] = -16'sd3;
      fim[255] = -16'sd4;
      push_expected();
      drive_frame(NP, NP - 1, 1'b1);
      wait_report(got);
      n_checks++;
      if (!got) begin
         n_fail++;
         $display("FAIL restart_report: got no peak_valid want one");
      end else begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_checks += 3;
         if (o.bin !== e.bin) begin n_fail++; $display("FAIL restart_bin: got %0d want %0d", o.bin, e.bin); end
         if (o.mag !== e.mag) begin n_fail++; $display("FAIL restart_mag: got %0d want %0d", o.mag, e.mag); end
         if (o.cyc - t_eop !== 5) begin n_fail++; $display("FAIL restart_latency: got %0d want 5", o.cyc - t_eop); end
      end
      n_checks++;
      if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL restart_err: got %0d pulses want 1", err_cnt - e0); end
   endtask

   task automatic test_reset_mid_frame();
      bit   got;
      rpt_t e;
      rpt_t o;
      int   e0 = err_cnt;
      clear_frame();
      fre[30] = 16'sd12345;
      drive_frame(250, -1, 1'b0);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n_checks += 5;
      if (ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got %b want 0", ready); end
      if (pvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_pvalid: got %b want 0", pvalid); end
      if (ferr !== 1'b0) begin n_fail++; $display("FAIL midrst_ferr: got %b want 0", ferr); end
      if (pbin !== '0) begin n_fail++; $display("FAIL midrst_bin: got %0d want 0", pbin); end
      if (pmag !== '0) begin n_fail++; $display("FAIL midrst_mag: got %0d want 0", pmag); end
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      n_checks += 2;
      if (obs_q.size() !== 0) begin n_fail++; $display("FAIL midrst_report: got %0d reports want 0", obs_q.size()); end
      if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL midrst_err: got %0d pulses want 0", err_cnt - e0); end
      // DC bin is larger but excluded; bin 1 is the lowest searchable bin.
      clear_frame();
      fre[0] = 16'sd30000;
      fre[1] = 16'sd1;
      push_expected();
      drive_frame(NP, NP - 1, 1'b0);
      wait_report(got);
      n_checks++;
      if (!got) begin
         n_fail++;
         $display("FAIL post_rst_report: got no peak_valid want one");
      end else begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_checks += 2;
         if (o.bin !== e.bin) begin n_fail++; $display("FAIL post_rst_bin: got %0d want %0d", o.bin, e.bin); end
         if (o.mag !== e.mag) begin n_fail++; $display("FAIL post_rst_mag: got %0d want %0d", o.mag, e.mag); end
      end
   endtask

   task automatic test_all_zero();
      bit   got;
      rpt_t e;
      rpt_t o;
      clear_frame();
      fre[300] = 16'sd500;
      push_expected();
      drive_frame(NP, NP - 1, 1'b0);
      wait_report(got);
      n_checks++;
      if (!got) begin
         n_fail++;
         $display("FAIL zero_report: got no peak_valid want one");
      end else begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_checks += 2;
         if (o.bin !== e.bin) begin n_fail++; $display("FAIL zero_bin: got %0d want %0d", o.bin, e.bin); end
         if (o.mag !== e.mag) begin n_fail++; $display("FAIL zero_mag: got %0d want %0d", o.mag, e.mag); end
      end
   endtask

   initial begin
      test_reset();
      test_single_tone();
      test_mirror_bin();
      test_tie_negative();
      test_early_eop();
      test_sop_restart();
      test_reset_mid_frame();
      test_all_zero();
      repeat (10) @(posedge clk);
      n_checks++;
      if (obs_q.size() !== 0 || exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL leftover_reports: got %0d observed, %0d expected unmatched, want 0",
                  obs_q.size(), exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
